// File: rtl/seg_scan_if.sv
// Bus between a display-value producer and the seven-segment scan controller.
// The producer side loads BCD values and sets blanking; the controller side
// returns the digit drive, the decoder nibble and status.
interface seg_scan_if #(
  parameter int NDIG = 4
);
  logic                load;
  logic [4*NDIG-1:0]   din;
  logic                lz_en;
  logic [3:0]          s_out;
  logic [NDIG-1:0]     an;
  logic                blank;
  logic                pending;
  logic                frame_tick;
  logic                err;

  modport master (
    output load, din, lz_en,
    input  s_out, an, blank, pending, frame_tick, err
  );

  modport slave (
    input  load, din, lz_en,
    output s_out, an, blank, pending, frame_tick, err
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit seven-segment display
// sharing one BCD decoder. The shown value is double-buffered (staging ->
// active at frame end) so a frame never mixes two values. Each digit slot
// begins with DEAD dark cycles to suppress ghosting. Digits holding a
// non-BCD nibble are dark with err raised; leading zeros can be blanked.
//
// state   | meaning
// --------+--------------------------------------------------------------
// cnt     | cycle within the current digit slot, 0..PRESC-1
// idx     | digit slot being scanned, 0..NDIG-1
// active  | value being displayed this frame
// staging | most recently loaded value, waiting for the frame boundary
// pending | staging holds a value not yet moved into active
module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int PRESC = 1000,
  parameter int DEAD  = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_scan_if.slave bus
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);

  logic [CW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [4*NDIG-1:0]   active, active_nxt;
  logic [4*NDIG-1:0]   staging, staging_nxt;
  logic                pending, pending_nxt;

  logic                cnt_last;
  logic                frame_end;
  logic [3:0]          cur_nib;
  logic                nib_err;
  logic                zero_run;
  logic                lz_hit;
  logic                lit;
  logic [NDIG-1:0]     an_d;

  // Slot/frame position decoded from registered counters only.
  assign cnt_last  = (cnt == CNT_LAST);
  assign frame_end = cnt_last && (idx == IDX_LAST);

  // State register: scan counters and the two value buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      active  <= '0;
      staging <= '0;
      pending <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      active  <= active_nxt;
      staging <= staging_nxt;
      pending <= pending_nxt;
    end
  end

  // Next state: advance the scan, accept loads, commit staging at frame end.
  // A load on the committing edge lands in staging after the old staging has
  // moved to active, so pending stays set for the following frame.
  always_comb begin
    cnt_nxt     = cnt_last ? '0 : cnt + CW'(1);
    idx_nxt     = idx;
    active_nxt  = active;
    staging_nxt = staging;
    pending_nxt = pending;
    if (cnt_last) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
    if (frame_end && pending) begin
      active_nxt  = staging;
      pending_nxt = 1'b0;
    end
    if (bus.load) begin
      staging_nxt = bus.din;
      pending_nxt = 1'b1;
    end
  end

  // Output decode: select the slot's nibble, evaluate blanking and drive
  // the digit enables. Everything is forced idle while reset is asserted so
  // the display goes dark the moment rst_n falls.
  always_comb begin
    cur_nib  = '0;
    zero_run = 1'b1;
    lz_hit   = 1'b0;
    an_d     = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == IW'(k)) cur_nib = active[4*k +: 4];
    end
    // Walk from the most significant digit down; zero_run stays high only
    // while every nibble seen so far is exactly zero.
    for (int k = NDIG - 1; k >= 1; k--) begin
      zero_run = zero_run && (active[4*k +: 4] == 4'd0);
      if (idx == IW'(k)) lz_hit = zero_run;
    end
    nib_err = (cur_nib > 4'd9);
    lit     = (cnt >= DEAD_C) && !nib_err && !(bus.lz_en && lz_hit);
    for (int k = 0; k < NDIG; k++) begin
      an_d[k] = rst_n && lit && (idx == IW'(k));
    end
    bus.an         = an_d;
    bus.blank      = ~|an_d;
    bus.err        = rst_n && nib_err;
    bus.s_out      = (rst_n && !nib_err) ? cur_nib : 4'd0;
    bus.frame_tick = rst_n && frame_end;
    bus.pending    = rst_n && pending;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, PRESC=8, DEAD=2.
// Cycle n is the n-th clock period after reset release; outputs are sampled
// on the falling edge and inputs change there too.
module tb_seg_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int PRESC = 8;
  localparam int DEAD  = 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   failed;

  seg_scan_if #(.NDIG(NDIG)) bus ();

  seg_scan_ctrl #(.NDIG(NDIG), .PRESC(PRESC), .DEAD(DEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the falling edge inside cycle n (n must be ahead of now).
  task automatic goto_cyc(input int n);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < n && guard < 2000);
    if (cyc != n) begin
      tests++;
      failed++;
      $display("FAIL goto_cyc: reached cycle %0d expected %0d", cyc, n);
    end
  endtask

  // Hold load high for cycle n; returns at the falling edge of cycle n+1.
  task automatic do_load(input int n, input logic [15:0] val);
    goto_cyc(n);
    bus.din  = val;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] an_e, input logic [3:0] s_e);
    chk({tag, ".an"}, 32'(bus.an), 32'(an_e));
    chk({tag, ".s_out"}, 32'(bus.s_out), 32'(s_e));
    chk({tag, ".blank"}, 32'(bus.blank), 32'(an_e == 4'd0));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    rst_n       = 1'b0;
    bus.load    = 1'b0;
    bus.din     = '0;
    bus.lz_en   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.an", 32'(bus.an), 32'h0);
    chk("rst.blank", 32'(bus.blank), 32'h1);
    chk("rst.pending", 32'(bus.pending), 32'h0);
    chk("rst.tick", 32'(bus.frame_tick), 32'h0);
    chk("rst.err", 32'(bus.err), 32'h0);
    release_reset();

    // Frame 0: all-zero value, dead time, slot stepping.
    goto_cyc(0);  chk_disp("c0", 4'b0000, 4'd0);
    goto_cyc(1);  chk_disp("c1", 4'b0000, 4'd0);
    goto_cyc(2);  chk_disp("c2", 4'b0001, 4'd0);
    do_load(5, 16'h1234);
    chk("c6.pending", 32'(bus.pending), 32'h1);
    goto_cyc(7);  chk_disp("c7", 4'b0001, 4'd0);
    goto_cyc(8);  chk_disp("c8", 4'b0000, 4'd0);
    goto_cyc(10); chk_disp("c10", 4'b0010, 4'd0);
    goto_cyc(30); chk_disp("c30", 4'b1000, 4'd0);
    chk("c30.tick", 32'(bus.frame_tick), 32'h0);
    goto_cyc(31); chk("c31.tick", 32'(bus.frame_tick), 32'h1);
    chk("c31.pending", 32'(bus.pending), 32'h1);

    // Frame 1: 1234 committed.
    goto_cyc(32); chk_disp("c32", 4'b0000, 4'd4);
    chk("c32.pending", 32'(bus.pending), 32'h0);
    chk("c32.tick", 32'(bus.frame_tick), 32'h0);
    goto_cyc(34); chk_disp("c34", 4'b0001, 4'd4);
    do_load(40, 16'h0045);
    chk("c41.pending", 32'(bus.pending), 32'h1);
    goto_cyc(42); chk_disp("c42", 4'b0010, 4'd3);
    goto_cyc(50); chk_disp("c50", 4'b0100, 4'd2);
    goto_cyc(58); chk_disp("c58", 4'b1000, 4'd1);
    goto_cyc(60); bus.lz_en = 1'b1;
    goto_cyc(63); chk("c63.tick", 32'(bus.frame_tick), 32'h1);

    // Frame 2: 0045 with leading-zero blanking.
    goto_cyc(66); chk_disp("c66", 4'b0001, 4'd5);
    do_load(70, 16'h0000);
    goto_cyc(74); chk_disp("c74", 4'b0010, 4'd4);
    goto_cyc(80); chk_disp("c80", 4'b0000, 4'd0);
    goto_cyc(84); chk_disp("c84", 4'b0000, 4'd0);
    goto_cyc(92); chk_disp("c92", 4'b0000, 4'd0);

    // Frame 3: 0000, only digit 0 lit; then blanking turned off mid-frame.
    goto_cyc(98);  chk_disp("c98", 4'b0001, 4'd0);
    do_load(100, 16'h12A4);
    goto_cyc(106); chk_disp("c106", 4'b0000, 4'd0);
    goto_cyc(110); bus.lz_en = 1'b0;
    goto_cyc(114); chk_disp("c114", 4'b0100, 4'd0);
    goto_cyc(124); chk_disp("c124", 4'b1000, 4'd0);

    // Frame 4: 12A4, slot 1 flagged as non-BCD.
    goto_cyc(130); chk_disp("c130", 4'b0001, 4'd4);
    chk("c130.err", 32'(bus.err), 32'h0);
    goto_cyc(136); chk_disp("c136", 4'b0000, 4'd0);
    chk("c136.err", 32'(bus.err), 32'h1);
    do_load(138, 16'h1111);
    goto_cyc(140); chk_disp("c140", 4'b0000, 4'd0);
    chk("c140.err", 32'(bus.err), 32'h1);
    goto_cyc(143); chk("c143.err", 32'(bus.err), 32'h1);
    goto_cyc(146); chk_disp("c146", 4'b0100, 4'd2);
    chk("c146.err", 32'(bus.err), 32'h0);
    goto_cyc(154); chk_disp("c154", 4'b1000, 4'd1);
    goto_cyc(159); chk("c159.tick", 32'(bus.frame_tick), 32'h1);
    // Load on the committing frame_tick cycle.
    bus.din  = 16'h2222;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;

    // Frame 5: 1111 displayed, 2222 still pending.
    chk("c160.pending", 32'(bus.pending), 32'h1);
    goto_cyc(162); chk_disp("c162", 4'b0001, 4'd1);
    goto_cyc(178); chk_disp("c178", 4'b0100, 4'd1);

    // Frame 6: 2222 displayed.
    goto_cyc(192); chk("c192.pending", 32'(bus.pending), 32'h0);
    goto_cyc(194); chk_disp("c194", 4'b0001, 4'd2);
    goto_cyc(218); chk_disp("c218", 4'b1000, 4'd2);
    // Load on frame_tick with nothing pending: active stays 2222.
    do_load(223, 16'h5678);
    chk("c224.pending", 32'(bus.pending), 32'h1);
    goto_cyc(226); chk_disp("c226", 4'b0001, 4'd2);

    // Frame 8: 5678 displayed, 9999 pending, then reset mid-frame.
    goto_cyc(258); chk_disp("c258", 4'b0001, 4'd8);
    do_load(260, 16'h9999);
    goto_cyc(276); chk_disp("c276", 4'b0100, 4'd6);
    chk("c276.pending", 32'(bus.pending), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.an", 32'(bus.an), 32'h0);
    chk("arst.blank", 32'(bus.blank), 32'h1);
    chk("arst.pending", 32'(bus.pending), 32'h0);
    chk("arst.s_out", 32'(bus.s_out), 32'h0);
    repeat (2) @(posedge clk);
    release_reset();

    goto_cyc(0);  chk_disp("r0", 4'b0000, 4'd0);
    goto_cyc(2);  chk_disp("r2", 4'b0001, 4'd0);
    chk("r2.pending", 32'(bus.pending), 32'h0);
    goto_cyc(10); chk_disp("r10", 4'b0010, 4'd0);
    goto_cyc(31); chk("r31.tick", 32'(bus.frame_tick), 32'h1);
    goto_cyc(34); chk_disp("r34", 4'b0001, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
